// File: rtl/jk_count_if.sv
// Bus between the JK excitation driver and its surroundings: control inputs,
// the feedback from the external JK bank, and the excitation/status outputs.
interface jk_count_if #(
  parameter int WIDTH = 4
);
  logic             En;
  logic             Up;
  logic             Load;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q_fb;
  logic [WIDTH-1:0] J;
  logic [WIDTH-1:0] K;
  logic [WIDTH-1:0] Cnt;
  logic             Tc;
  logic             Err;

  // Environment side: drives control and bank feedback, observes excitation.
  modport master (
    output En, Up, Load, D, Q_fb,
    input  J, K, Cnt, Tc, Err
  );

  // Driver side: the jk_count_driver block.
  modport slave (
    input  En, Up, Load, D, Q_fb,
    output J, K, Cnt, Tc, Err
  );
endinterface

// File: rtl/jk_count_driver.sv
// JK excitation generator: keeps a shadow modulo-MOD up/down count and drives
// J/K so an external JK bank follows it; flags any divergence of the bank's Q.
module jk_count_driver #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic     Clk,
  input  logic     Rst,
  jk_count_if.slave bus
);

  // The load-range compare is one bit wider because the modulus may equal 2**WIDTH.
  localparam logic [WIDTH:0]   MOD_C = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_C = {WIDTH{1'b1}};

  logic [WIDTH-1:0] cnt_r;
  logic             err_r;
  logic [WIDTH-1:0] nxt_s;
  logic             load_bad_s;
  logic [WIDTH-1:0] j_s;
  logic [WIDTH-1:0] k_s;
  logic             tc_s;
  logic             err_nxt_s;

  // Next-count selection in priority order: reset, load, count, hold.
  always_comb begin
    nxt_s      = cnt_r;
    load_bad_s = 1'b0;
    if (Rst) begin
      nxt_s = ZERO_C;
    end else if (bus.Load) begin
      if ({1'b0, bus.D} < MOD_C) begin
        nxt_s = bus.D;
      end else begin
        nxt_s      = ZERO_C;
        load_bad_s = 1'b1;
      end
    end else if (bus.En) begin
      if (bus.Up) begin
        if (cnt_r == MAX_C) begin
          nxt_s = ZERO_C;
        end else begin
          nxt_s = cnt_r + WIDTH'(1);
        end
      end else begin
        if (cnt_r == ZERO_C) begin
          nxt_s = MAX_C;
        end else begin
          nxt_s = cnt_r - WIDTH'(1);
        end
      end
    end else begin
      nxt_s = cnt_r;
    end
  end

  // Excitation: set bits that rise, reset bits that fall; during reset clear the whole bank.
  always_comb begin
    j_s = ZERO_C;
    k_s = ZERO_C;
    if (Rst) begin
      j_s = ZERO_C;
      k_s = ONES_C;
    end else begin
      j_s = ~cnt_r & nxt_s;
      k_s =  cnt_r & ~nxt_s;
    end
  end

  // Terminal count: the next enabled step in the current direction wraps.
  always_comb begin
    tc_s = 1'b0;
    if (bus.En && !bus.Load && !Rst) begin
      tc_s = (bus.Up && (cnt_r == MAX_C)) || (!bus.Up && (cnt_r == ZERO_C));
    end else begin
      tc_s = 1'b0;
    end
  end

  // Sticky error: bank feedback mismatch or an out-of-range load.
  always_comb begin
    err_nxt_s = err_r;
    if (Rst) begin
      err_nxt_s = 1'b0;
    end else begin
      err_nxt_s = err_r | (bus.Q_fb != cnt_r) | load_bad_s;
    end
  end

  // State register: shadow count and error flag.
  always_ff @(posedge Clk) begin
    cnt_r <= nxt_s;
    err_r <= err_nxt_s;
  end

  assign bus.J   = j_s;
  assign bus.K   = k_s;
  assign bus.Tc  = tc_s;
  assign bus.Cnt = cnt_r;
  assign bus.Err = err_r;

endmodule

// File: tb/tb_jk_count_driver.sv
// Directed bench for jk_count_driver (WIDTH=4, MOD=10) with a behavioural JK
// bank in the feedback loop and a stuck-at fault injectable on Q_fb[2].
module tb_jk_count_driver;

  logic       clk;
  logic       rst;
  logic       fault;
  logic [3:0] q_bank;
  logic [3:0] exp_cnt;
  logic [3:0] exp_nxt;
  int         n_checks;
  int         n_pass;

  jk_count_if #(.WIDTH(4)) bus ();

  jk_count_driver #(.WIDTH(4), .MOD(10)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural JK flip-flop bank driven by the DUT's excitation.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      case ({bus.J[i], bus.K[i]})
        2'b10:   q_bank[i] <= 1'b1;
        2'b01:   q_bank[i] <= 1'b0;
        2'b11:   q_bank[i] <= ~q_bank[i];
        default: q_bank[i] <= q_bank[i];
      endcase
    end
  end

  assign bus.Q_fb = fault ? (q_bank & 4'b1011) : q_bank;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] model_next(input logic [3:0] c, input logic ld,
                                            input logic [3:0] d, input logic en,
                                            input logic up);
    if (ld)      return (d < 4'd10) ? d : 4'd0;
    else if (en) begin
      if (up)    return (c == 4'd9) ? 4'd0 : c + 4'd1;
      else       return (c == 4'd0) ? 4'd9 : c - 4'd1;
    end
    else         return c;
  endfunction

  initial begin
    n_checks = 0;
    n_pass   = 0;
    q_bank   = 4'd0;
    fault    = 1'b0;
    rst      = 1'b1;
    bus.En   = 1'b0;
    bus.Up   = 1'b0;
    bus.Load = 1'b0;
    bus.D    = 4'd0;

    // 1. Reset for two cycles, then release with En=0.
    tick();
    tick();
    check("rst_j",   32'(bus.J),   32'h0);
    check("rst_k",   32'(bus.K),   32'hf);
    check("rst_cnt", 32'(bus.Cnt), 32'h0);
    check("rst_err", 32'(bus.Err), 32'h0);
    rst = 1'b0;
    #1;
    check("idle_j", 32'(bus.J), 32'h0);
    check("idle_k", 32'(bus.K), 32'h0);
    tick();
    check("idle_cnt", 32'(bus.Cnt), 32'h0);
    check("idle_err", 32'(bus.Err), 32'h0);

    // 2. Count up 12 cycles: 1..9,0,1,2.
    exp_cnt = 4'd0;
    bus.En  = 1'b1;
    bus.Up  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (exp_cnt == 4'd9) begin
        check("up_tc9", 32'(bus.Tc), 32'h1);
        check("up_j9",  32'(bus.J),  32'h0);
        check("up_k9",  32'(bus.K),  32'h9);
      end else begin
        check("up_tc", 32'(bus.Tc), 32'h0);
      end
      tick();
      exp_cnt = (exp_cnt == 4'd9) ? 4'd0 : exp_cnt + 4'd1;
      check("up_cnt", 32'(bus.Cnt), 32'(exp_cnt));
    end
    check("up_end", 32'(bus.Cnt), 32'h2);

    // 3. Count down 2 -> 1 -> 0 -> 9 -> 8 -> 7.
    bus.Up = 1'b0;
    #1;
    check("dn_tc2", 32'(bus.Tc), 32'h0);
    tick();
    check("dn_cnt1", 32'(bus.Cnt), 32'h1);
    tick();
    check("dn_cnt0", 32'(bus.Cnt), 32'h0);
    #1;
    check("dn_tc0", 32'(bus.Tc), 32'h1);
    check("dn_j0",  32'(bus.J),  32'h9);
    check("dn_k0",  32'(bus.K),  32'h0);
    tick();
    check("dn_wrap", 32'(bus.Cnt), 32'h9);
    #1;
    check("dn_tc9", 32'(bus.Tc), 32'h0);
    check("dn_j9",  32'(bus.J),  32'h0);
    check("dn_k9",  32'(bus.K),  32'h1);
    tick();
    check("dn_cnt8", 32'(bus.Cnt), 32'h8);
    #1;
    check("dn_j8", 32'(bus.J), 32'h7);
    check("dn_k8", 32'(bus.K), 32'h8);
    tick();
    check("dn_cnt7", 32'(bus.Cnt), 32'h7);

    // 4. Load has priority over En; out-of-range loads set sticky Err.
    bus.Load = 1'b1;
    bus.D    = 4'd5;
    #1;
    check("ld_tc", 32'(bus.Tc), 32'h0);
    check("ld_j",  32'(bus.J),  32'h0);
    check("ld_k",  32'(bus.K),  32'h2);
    tick();
    check("ld_cnt5", 32'(bus.Cnt), 32'h5);
    #1;
    check("ld_same_j", 32'(bus.J), 32'h0);
    check("ld_same_k", 32'(bus.K), 32'h0);
    tick();
    check("ld_same_cnt", 32'(bus.Cnt), 32'h5);
    bus.D = 4'd12;
    tick();
    check("ld12_cnt", 32'(bus.Cnt), 32'h0);
    check("ld12_err", 32'(bus.Err), 32'h1);
    bus.Load = 1'b0;
    bus.En   = 1'b0;
    tick();
    tick();
    check("err_sticky", 32'(bus.Err), 32'h1);
    rst = 1'b1;
    tick();
    check("err_clr", 32'(bus.Err), 32'h0);
    rst      = 1'b0;
    bus.Load = 1'b1;
    bus.D    = 4'd9;
    tick();
    check("ld9_cnt", 32'(bus.Cnt), 32'h9);
    check("ld9_err", 32'(bus.Err), 32'h0);
    bus.D = 4'd10;
    tick();
    check("ld10_cnt", 32'(bus.Cnt), 32'h0);
    check("ld10_err", 32'(bus.Err), 32'h1);
    bus.Load = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;

    // 5. Random En/Up/Load with the bank in the loop.
    exp_cnt = 4'd0;
    for (int i = 0; i < 200; i++) begin
      bus.En   = 1'($urandom_range(0, 1));
      bus.Up   = 1'($urandom_range(0, 1));
      bus.Load = ($urandom_range(0, 7) == 0);
      bus.D    = 4'($urandom_range(0, 9));
      exp_nxt  = model_next(exp_cnt, bus.Load, bus.D, bus.En, bus.Up);
      #1;
      check("rnd_jk", 32'(bus.J & bus.K), 32'h0);
      check("rnd_j",  32'(bus.J), 32'(~exp_cnt & exp_nxt));
      check("rnd_k",  32'(bus.K), 32'(exp_cnt & ~exp_nxt));
      tick();
      exp_cnt = exp_nxt;
      check("rnd_cnt", 32'(bus.Cnt),  32'(exp_cnt));
      check("rnd_q",   32'(bus.Q_fb), 32'(exp_cnt));
    end
    check("rnd_err", 32'(bus.Err), 32'h0);

    // 6. Stuck-at-0 on Q_fb[2] while counting, then reset mid-count.
    bus.Load = 1'b0;
    bus.En   = 1'b0;
    rst      = 1'b1;
    tick();
    rst    = 1'b0;
    fault  = 1'b1;
    bus.En = 1'b1;
    bus.Up = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("flt_cnt4", 32'(bus.Cnt), 32'h4);
    check("flt_err0", 32'(bus.Err), 32'h0);
    tick();
    check("flt_err1", 32'(bus.Err), 32'h1);
    tick();
    tick();
    check("flt_cnt7", 32'(bus.Cnt), 32'h7);
    fault = 1'b0;
    rst   = 1'b1;
    bus.Load = 1'b1;
    bus.D    = 4'd3;
    #1;
    check("mid_rst_k", 32'(bus.K), 32'hf);
    tick();
    check("mid_rst_cnt", 32'(bus.Cnt), 32'h0);
    check("mid_rst_err", 32'(bus.Err), 32'h0);
    rst      = 1'b0;
    bus.Load = 1'b0;
    tick();
    check("resume_cnt", 32'(bus.Cnt), 32'h1);
    check("resume_err", 32'(bus.Err), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
